// File: rtl/exmple_pserial_tx.sv
// Parallel-to-serial transmitter: start bit, DSIZE data bits LSB first,
// optional even parity, stop bit; every bit held for DIV clock cycles.
module exmple_pserial_tx #(
  parameter int DSIZE  = 8,
  parameter int DIV    = 4,
  parameter int PARITY = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] pdata,
  input  logic             pvalid,
  output logic             pready,
  output logic             sdata,
  output logic             sbusy,
  output logic             sdone
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(DSIZE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DSIZE - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]       state,   state_d;
  logic [DW-1:0]    div_cnt, div_cnt_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [DSIZE-1:0] shreg,   shreg_d;
  logic             par_bit, par_d;
  logic             sdata_d, pready_d, sbusy_d, sdone_d;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  // Next-state logic computes the value every register takes on the next
  // edge, so all outputs come straight from flops.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d   = state;
    div_cnt_d = div_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    par_d     = par_bit;
    sdata_d   = sdata;
    pready_d  = pready;
    sbusy_d   = sbusy;

    if (state == IDLE) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      sdata_d   = 1'b1;
      pready_d  = 1'b1;
      sbusy_d   = 1'b0;
      if (pvalid && pready) begin
        state_d  = START;
        shreg_d  = pdata;
        par_d    = ^pdata;
        sdata_d  = 1'b0;
        pready_d = 1'b0;
        sbusy_d  = 1'b1;
      end
    end else if (!div_wrap) begin
      div_cnt_d = div_cnt + 1'b1;
    end else begin
      div_cnt_d = '0;
      case (state)
        START: begin
          state_d = DATA;
          sdata_d = shreg[0];
          shreg_d = shreg >> 1;
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              sdata_d = par_bit;
            end else begin
              state_d = STOP;
              sdata_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
            sdata_d   = shreg[0];
            shreg_d   = shreg >> 1;
          end
        end
        PAR: begin
          state_d = STOP;
          sdata_d = 1'b1;
        end
        default: begin
          // STOP completion, or recovery from an unreachable encoding.
          state_d   = IDLE;
          bit_cnt_d = '0;
          sdata_d   = 1'b1;
          pready_d  = 1'b1;
          sbusy_d   = 1'b0;
        end
      endcase
    end

    // sdone marks the final divider tick of STOP, including DIV=1.
    sdone_d = (state_d == STOP) && (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      sdata   <= 1'b1;
      pready  <= 1'b1;
      sbusy   <= 1'b0;
      sdone   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_d;
      div_cnt <= div_cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      par_bit <= par_d;
      sdata   <= sdata_d;
      pready  <= pready_d;
      sbusy   <= sbusy_d;
      sdone   <= sdone_d;
    end
  end

endmodule

// File: tb/tb_exmple_pserial_tx.sv
// Bench for exmple_pserial_tx: three instances (no parity DIV=4, parity DIV=4,
// no parity DIV=1) checked cycle by cycle against hand-written frame bits.
module tb_exmple_pserial_tx;

  logic       clock;
  logic       rst_n;
  logic [2:0] pvalid;
  logic [7:0] pdata [3];
  logic [2:0] pready, sdata, sbusy, sdone;

  int nvec = 0;
  int nerr = 0;

  localparam logic [3:0] IDLE_OUT = 4'b1010; // {sdata, sbusy, pready, sdone}

  exmple_pserial_tx #(.DSIZE(8), .DIV(4), .PARITY(0)) u_p0 (
    .clock(clock), .rst_n(rst_n), .pdata(pdata[0]), .pvalid(pvalid[0]),
    .pready(pready[0]), .sdata(sdata[0]), .sbusy(sbusy[0]), .sdone(sdone[0]));

  exmple_pserial_tx #(.DSIZE(8), .DIV(4), .PARITY(1)) u_p1 (
    .clock(clock), .rst_n(rst_n), .pdata(pdata[1]), .pvalid(pvalid[1]),
    .pready(pready[1]), .sdata(sdata[1]), .sbusy(sbusy[1]), .sdone(sdone[1]));

  exmple_pserial_tx #(.DSIZE(8), .DIV(1), .PARITY(0)) u_d1 (
    .clock(clock), .rst_n(rst_n), .pdata(pdata[2]), .pvalid(pvalid[2]),
    .pready(pready[2]), .sdata(sdata[2]), .sbusy(sbusy[2]), .sdone(sdone[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          sel;
    int          div;
    logic [7:0]  data;
    logic [10:0] bits;   // transmitted bits, bit 0 first
    int          nbits;
  } vec_t;

  vec_t vecs[6];

  task automatic check_now(input int sel, input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {sdata[sel], sbusy[sel], pready[sel], sdone[sel]};
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got {sdata,sbusy,pready,sdone}=%b want %b", name, sel, got, exp);
    end
  endtask

  task automatic sample(input int sel, input string name, input logic [3:0] exp);
    @(negedge clock);
    check_now(sel, name, exp);
  endtask

  // Caller has raised pvalid before the accept edge; cycle c lies between
  // edges E0+c-1 and E0+c.
  task automatic expect_frame(input int sel, input int div, input logic [10:0] bits,
                              input int nbits, input bit hold, input int mod_cycle,
                              input logic [7:0] mod_data, input string name);
    int len;
    len = nbits * div;
    for (int c = 1; c <= len; c++) begin
      sample(sel, $sformatf("%s c%0d", name, c), {bits[(c-1)/div], 1'b1, 1'b0, c == len});
      if (c == 1) pvalid[sel] = hold;
      if (c == mod_cycle) begin
        pdata[sel]  = mod_data;
        pvalid[sel] = 1'b1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 4, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
    vecs[1] = '{0, 4, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 10};
    vecs[2] = '{0, 4, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}, 10};
    vecs[3] = '{1, 4, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11};
    vecs[4] = '{1, 4, 8'h03, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11};
    vecs[5] = '{2, 1, 8'h5A, {2'b00, 1'b1, 8'h5A, 1'b0}, 10};

    rst_n  = 1'b0;
    pvalid = '0;
    for (int i = 0; i < 3; i++) pdata[i] = 8'h00;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) check_now(i, "reset", IDLE_OUT);

    rst_n = 1'b1;
    for (int k = 0; k < 20; k++)
      for (int i = 0; i < 3; i++) if (k % 10 == 9) check_now(i, "idle_hold", IDLE_OUT);
    repeat (20) sample(0, "idle_wait", IDLE_OUT);

    foreach (vecs[v]) begin
      pdata[vecs[v].sel]  = vecs[v].data;
      pvalid[vecs[v].sel] = 1'b1;
      expect_frame(vecs[v].sel, vecs[v].div, vecs[v].bits, vecs[v].nbits, 1'b0, 0, 8'h00,
                   $sformatf("vec%0d", v));
      sample(vecs[v].sel, $sformatf("vec%0d_end", v), IDLE_OUT);
    end

    // Back-to-back with pvalid held, DIV=1: one idle cycle between frames.
    pdata[2]  = 8'h01;
    pvalid[2] = 1'b1;
    expect_frame(2, 1, {2'b00, 1'b1, 8'h01, 1'b0}, 10, 1'b1, 1, 8'hFE, "b2b_f1");
    sample(2, "b2b_gap", IDLE_OUT);
    expect_frame(2, 1, {2'b00, 1'b1, 8'hFE, 1'b0}, 10, 1'b0, 0, 8'h00, "b2b_f2");
    sample(2, "b2b_end", IDLE_OUT);

    // pdata change mid-frame is ignored; the new word waits for pready.
    pdata[0]  = 8'h00;
    pvalid[0] = 1'b1;
    expect_frame(0, 4, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 1'b0, 5, 8'hFF, "hold_f1");
    sample(0, "hold_gap", IDLE_OUT);
    expect_frame(0, 4, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 0, 8'h00, "hold_f2");
    sample(0, "hold_end", IDLE_OUT);

    // Asynchronous reset at E0+17 aborts the frame with no sdone.
    pdata[0]  = 8'h3C;
    pvalid[0] = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      sample(0, $sformatf("abort c%0d", c), {c <= 4 ? 1'b0 : pdata[0][(c-5)/4], 1'b1, 1'b0, 1'b0});
      if (c == 1) pvalid[0] = 1'b0;
    end
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1 check_now(0, "abort_now", IDLE_OUT);
    repeat (3) sample(0, "abort_held", IDLE_OUT);
    rst_n     = 1'b1;
    pdata[0]  = 8'h81;
    pvalid[0] = 1'b1;
    expect_frame(0, 4, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 1'b0, 0, 8'h00, "post_reset");
    repeat (5) sample(0, "post_idle", IDLE_OUT);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
